// File: rtl/display_scan_scheduler.sv
// Eight-digit seven-segment scan with per-slot anti-ghost blanking, leading-zero blanking and per-frame input snapshot.
// Latency: outputs registered, aligned with the internal cnt/idx/state; no backpressure (free-running display pins).
module display_scan_scheduler #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LZB          = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  output logic [6:0]  segments,
  output logic [7:0]  anodos,
  output logic        frame_start
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [31:0]   snap, snap_nxt;
  logic [7:0]    snap_en, en_nxt;
  logic          first;
  logic          wrap, capture, upper_zero, lit;
  logic [3:0]    cur;
  logic [6:0]    seg_nxt;
  logic [7:0]    an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0:    hex7 = 7'b0000001;
      4'h1:    hex7 = 7'b1001111;
      4'h2:    hex7 = 7'b0010010;
      4'h3:    hex7 = 7'b0000110;
      4'h4:    hex7 = 7'b1001100;
      4'h5:    hex7 = 7'b0100100;
      4'h6:    hex7 = 7'b0100000;
      4'h7:    hex7 = 7'b0001111;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0000100;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b1100000;
      4'hC:    hex7 = 7'b0110001;
      4'hD:    hex7 = 7'b1000010;
      4'hE:    hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    wrap      = (cnt == CNT_LAST);
    // First cycle out of reset behaves like a frame boundary so the snapshot is never stale
    capture   = first || (wrap && idx == 3'd7);
    cnt_nxt   = wrap ? '0 : cnt + CW'(1);
    idx_nxt   = wrap ? idx + 3'd1 : idx;
    state_nxt = state;
    if (wrap)
      state_nxt = BLANK;
    else if (state == BLANK && cnt == BLANK_LAST)
      state_nxt = SHOW;
    snap_nxt = capture ? digits : snap;
    en_nxt   = capture ? digit_en : snap_en;
    cur      = snap_nxt[{idx_nxt, 2'b00} +: 4];

    upper_zero = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j >= int'(idx_nxt) && snap_nxt[4*j +: 4] != 4'h0)
        upper_zero = 1'b0;
    end

    lit     = (state_nxt == SHOW) && en_nxt[idx_nxt]
              && !(LZB && idx_nxt != 3'd0 && upper_zero);
    seg_nxt = lit ? hex7(cur) : 7'h7F;
    an_nxt  = lit ? ~(8'h01 << idx_nxt) : 8'hFF;
  end

  // Outputs are registered from the next-state values so they line up with cnt/idx
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 3'd0;
      snap        <= 32'h0;
      snap_en     <= 8'h00;
      first       <= 1'b1;
      segments    <= 7'h7F;
      anodos      <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      snap        <= snap_nxt;
      snap_en     <= en_nxt;
      first       <= 1'b0;
      segments    <= seg_nxt;
      anodos      <= an_nxt;
      frame_start <= capture;
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler at TICK_DIV=10, BLANK_CYCLES=2; one LZB=0 and one LZB=1 instance.
module tb_display_scan_scheduler;

  logic        clock;
  logic        reset;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [6:0]  segments;
  logic [7:0]  anodos;
  logic        frame_start;

  logic [31:0] lz_digits;
  logic [7:0]  lz_en;
  logic [6:0]  lz_segments;
  logic [7:0]  lz_anodos;
  logic        lz_frame_start;

  int checks   = 0;
  int failures = 0;

  // Active-low CA..CG patterns for hex 0..F
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // digits 32'h00000A05 with LZB: slot0 '5', slot1 '0', slot2 'A', slots 3..7 dark
  logic [6:0] lz_pat [3] = '{7'b0100100, 7'b0000001, 7'b0001000};

  display_scan_scheduler #(.TICK_DIV(10), .BLANK_CYCLES(2), .LZB(1'b0)) dut (
    .clock(clock), .reset(reset), .digits(digits), .digit_en(digit_en),
    .segments(segments), .anodos(anodos), .frame_start(frame_start)
  );

  display_scan_scheduler #(.TICK_DIV(10), .BLANK_CYCLES(2), .LZB(1'b1)) dut_lzb (
    .clock(clock), .reset(reset), .digits(lz_digits), .digit_en(lz_en),
    .segments(lz_segments), .anodos(lz_anodos), .frame_start(lz_frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_val(tag, {31'h0, frame_start}, 32'h1);
  endtask

  function automatic logic [7:0] exp_an(input int cc, input int slot, input bit on);
    return (cc < 2 || !on) ? 8'hFF : ~(8'h01 << slot);
  endfunction

  function automatic logic [6:0] exp_seg(input int cc, input bit on, input logic [6:0] pat);
    return (cc < 2 || !on) ? 7'h7F : pat;
  endfunction

  initial begin
    reset     = 1'b1;
    digits    = 32'h76543210;
    digit_en  = 8'hFF;
    lz_digits = 32'h00000A05;
    lz_en     = 8'hFF;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_an", anodos, 8'hFF);
      check_val("rst_seg", segments, 7'h7F);
      check_val("rst_fs", frame_start, 1'b0);
    end
    reset = 1'b0;
    check_val("rel0_an", anodos, 8'hFF);
    check_val("rel0_fs", frame_start, 1'b0);

    // Two full frames of sequencing, both instances checked every cycle
    for (int c = 1; c <= 161; c++) begin
      int slot, cc;
      tick();
      slot = (c / 10) % 8;
      cc   = c % 10;
      check_val("seq_fs", frame_start, (c == 1 || c % 80 == 0) ? 1 : 0);
      check_val("seq_an", anodos, exp_an(cc, slot, 1'b1));
      check_val("seq_seg", segments, exp_seg(cc, 1'b1, seg_tab[slot]));
      check_val("lzb_an", lz_anodos, exp_an(cc, slot, slot < 3));
      check_val("lzb_seg", lz_segments, exp_seg(cc, slot < 3, slot < 3 ? lz_pat[slot] : 7'h7F));
    end

    // Snapshot: change at frame cycle 35 is invisible until the next frame; then enable mask
    digits = 32'h11111111;
    wait_frame("snap_wait");
    for (int f = 1; f <= 240; f++) begin
      int slot, cc;
      bit on;
      tick();
      slot = (f / 10) % 8;
      cc   = f % 10;
      on   = (f < 160) ? 1'b1 : (slot == 0);
      check_val("snap_fs", frame_start, (f % 80 == 0) ? 1 : 0);
      check_val("snap_an", anodos, exp_an(cc, slot, on));
      check_val("snap_seg", segments, exp_seg(cc, on, (f < 80) ? seg_tab[1] : seg_tab[2]));
      if (f == 35)  digits   = 32'h22222222;
      if (f == 159) digit_en = 8'h01;
      if (f == 239) digit_en = 8'hFF;
    end

    // Mid-slot reset at idx=3, cnt=5
    repeat (35) tick();
    check_val("mid_pre_an", anodos, 8'hF7);
    check_val("mid_pre_seg", segments, seg_tab[2]);
    reset = 1'b1;
    tick();
    check_val("mid_rst_an", anodos, 8'hFF);
    check_val("mid_rst_seg", segments, 7'h7F);
    check_val("mid_rst_fs", frame_start, 1'b0);
    tick();
    reset = 1'b0;
    check_val("mid_rel0_an", anodos, 8'hFF);
    tick();
    check_val("mid_rel1_fs", frame_start, 1'b1);
    check_val("mid_rel1_an", anodos, 8'hFF);
    tick();
    check_val("mid_rel2_fs", frame_start, 1'b0);
    check_val("mid_rel2_an", anodos, 8'hFE);
    check_val("mid_rel2_seg", segments, seg_tab[2]);
    repeat (10) tick();
    check_val("mid_rel12_an", anodos, 8'hFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
